// File: rtl/proc_io_pkg.sv
// Shared constants and helpers for the processor I/O bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package proc_io_pkg;

    // Bit positions inside the sticky err vector
    localparam int ERR_UNDR = 0;
    localparam int ERR_OVRN = 1;
    localparam int ERR_W    = 2;

    typedef logic [ERR_W-1:0] err_t;

    // Low bit of channel i on a bus that packs w-bit channels side by side
    function automatic int chan_slice(input int i, input int w = 16);
        return i * w;
    endfunction

endpackage

// File: rtl/proc_io_bridge_io_slot.sv
// One-entry holding slot: write fills it, read empties it, data is kept after a read.
// Latency: fill/empty take effect at the next clock edge; o_dat is the register output.
// Backpressure: the owner gates i_wr with ~o_full where overwrite is not wanted; a write wins over a read.
module io_slot #(
    parameter int NUBITS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr,
    input  logic              i_rd,
    input  logic [NUBITS-1:0] i_dat,
    output logic [NUBITS-1:0] o_dat,
    output logic              o_full
);

    logic              r_full;
    logic [NUBITS-1:0] r_hold;

    // Occupancy and data register; a same-cycle write keeps the slot full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_hold <= '0;
        end else if (i_wr) begin
            r_full <= 1'b1;
            r_hold <= i_dat;
        end else if (i_rd) begin
            r_full <= 1'b0;
        end
    end

    assign o_dat  = r_hold;
    assign o_full = r_full;

endmodule

// File: rtl/proc_io_bridge.sv
// Processor port-bus responder: per-channel input slots for reads, output slots for writes, sticky errors, optional itr.
// Latency: reads are combinational (slot frees next edge); writes show on out_data/out_valid one edge later.
// Backpressure: in_ready = slot empty; out_valid held until out_ready; itr logic only when PROC_IO_ITR_EN is defined.
module proc_io_bridge
    import proc_io_pkg::*;
#(
    parameter int                 NUBITS = 16,
    parameter int                 NUIOIN = 2,
    parameter int                 NUIOOU = 2,
    parameter logic [NUIOIN-1:0]  ITRMSK = '1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [NUBITS-1:0]          io_in,
    input  logic [$clog2(NUIOIN)-1:0]  addr_in,
    input  logic                       req_in,
    input  logic [NUBITS-1:0]          io_out,
    input  logic [$clog2(NUIOOU)-1:0]  addr_out,
    input  logic                       out_en,
    output logic                       itr,
    input  logic [NUIOIN*NUBITS-1:0]   in_data,
    input  logic [NUIOIN-1:0]          in_valid,
    output logic [NUIOIN-1:0]          in_ready,
    output logic [NUIOOU*NUBITS-1:0]   out_data,
    output logic [NUIOOU-1:0]          out_valid,
    input  logic [NUIOOU-1:0]          out_ready,
    output logic [1:0]                 err
);

    localparam int AWI = $clog2(NUIOIN);
    localparam int AWO = $clog2(NUIOOU);

    // ---------------------------------------------------------------
    // Input side: producers fill, processor reads
    // ---------------------------------------------------------------
    logic              w_rd_ok;
    logic [NUIOIN-1:0] w_in_sel;
    logic [NUIOIN-1:0] w_in_wr;
    logic [NUIOIN-1:0] w_in_rd;
    logic [NUIOIN-1:0] w_in_full;
    logic [NUBITS-1:0] w_in_hold [NUIOIN];

    // Channel counts that are not a power of two leave unused address codes
    assign w_rd_ok = (int'(addr_in) < NUIOIN);

    for (genvar gi = 0; gi < NUIOIN; gi++) begin : g_in
        localparam logic [AWI-1:0] IDX = AWI'(gi);

        assign w_in_sel[gi] = w_rd_ok & (addr_in == IDX);
        // Producer is only accepted into an empty slot
        assign w_in_wr[gi]  = in_valid[gi] & ~w_in_full[gi];
        assign w_in_rd[gi]  = req_in & w_in_sel[gi];

        io_slot #(.NUBITS(NUBITS)) u_in_slot (
            .clk    (clk),
            .rst    (rst),
            .i_wr   (w_in_wr[gi]),
            .i_rd   (w_in_rd[gi]),
            .i_dat  (in_data[chan_slice(gi, NUBITS) +: NUBITS]),
            .o_dat  (w_in_hold[gi]),
            .o_full (w_in_full[gi])
        );
    end

    assign in_ready = ~w_in_full;

    // Read data mux; an out-of-range address returns zero
    always_comb begin
        io_in = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (w_in_sel[k]) begin
                io_in = w_in_hold[k];
            end
        end
    end

    // A read of an empty slot (including one being filled this cycle) is an underrun
    logic w_undr;
    assign w_undr = req_in & w_rd_ok & ~(|(w_in_sel & w_in_full));

    // ---------------------------------------------------------------
    // Output side: processor writes, consumers drain
    // ---------------------------------------------------------------
    logic              w_wr_ok;
    logic [NUIOOU-1:0] w_out_wr;
    logic [NUIOOU-1:0] w_out_rd;
    logic [NUIOOU-1:0] w_out_full;
    logic [NUBITS-1:0] w_out_dat [NUIOOU];

    assign w_wr_ok = (int'(addr_out) < NUIOOU);

    for (genvar gj = 0; gj < NUIOOU; gj++) begin : g_out
        localparam logic [AWO-1:0] IDX = AWO'(gj);

        assign w_out_wr[gj] = out_en & w_wr_ok & (addr_out == IDX);
        assign w_out_rd[gj] = w_out_full[gj] & out_ready[gj];

        // Processor writes are never blocked; a write to a full slot replaces the data
        io_slot #(.NUBITS(NUBITS)) u_out_slot (
            .clk    (clk),
            .rst    (rst),
            .i_wr   (w_out_wr[gj]),
            .i_rd   (w_out_rd[gj]),
            .i_dat  (io_out),
            .o_dat  (w_out_dat[gj]),
            .o_full (w_out_full[gj])
        );

        assign out_data[chan_slice(gj, NUBITS) +: NUBITS] = w_out_dat[gj];
    end

    assign out_valid = w_out_full;

    // Overwrite of data the consumer has not taken yet is an overrun
    logic w_ovrn;
    assign w_ovrn = |(w_out_wr & w_out_full & ~out_ready);

    // ---------------------------------------------------------------
    // Sticky error flags
    // ---------------------------------------------------------------
    err_t r_err;

    // Errors accumulate until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            if (w_undr) r_err[ERR_UNDR] <= 1'b1;
            if (w_ovrn) r_err[ERR_OVRN] <= 1'b1;
        end
    end

    assign err = r_err;

    // ---------------------------------------------------------------
    // Interrupt
    // ---------------------------------------------------------------
`ifdef PROC_IO_ITR_EN
    logic w_pend;
    logic r_pend_q;
    logic r_itr;

    assign w_pend = |(w_in_full & ITRMSK);

    // One-cycle pulse on the rising edge of pending masked input data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_q <= 1'b0;
            r_itr    <= 1'b0;
        end else begin
            r_pend_q <= w_pend;
            r_itr    <= w_pend & ~r_pend_q;
        end
    end

    assign itr = r_itr;
`else
    // Interrupt disabled: the mask has no effect
    logic w_unused_itrmsk;
    assign w_unused_itrmsk = ^ITRMSK;
    assign itr             = 1'b0;
`endif

endmodule

// File: tb/tb_proc_io_bridge.sv
// Directed bench for proc_io_bridge with a queue-based scoreboard on read data and consumer drains.
module tb_proc_io_bridge;

`ifdef PROC_IO_ITR_EN
    localparam int ITR_ON = 1;
`else
    localparam int ITR_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] io_in;
    logic [0:0]  addr_in;
    logic        req_in;
    logic [15:0] io_out;
    logic [0:0]  addr_out;
    logic        out_en;
    logic        itr;
    logic [31:0] in_data;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [1:0]  err;

    int n_chk   = 0;
    int n_pass  = 0;
    int itr_cnt = 0;
    int exp_itr = 0;

    logic [15:0] q_rd[$];
    logic [15:0] q_out0[$];
    logic [15:0] q_out1[$];

    proc_io_bridge #(.NUBITS(16), .NUIOIN(2), .NUIOOU(2), .ITRMSK(2'b11)) dut (
        .clk       (clk),
        .rst       (rst),
        .io_in     (io_in),
        .addr_in   (addr_in),
        .req_in    (req_in),
        .io_out    (io_out),
        .addr_out  (addr_out),
        .out_en    (out_en),
        .itr       (itr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected values whenever the DUT presents read data or a consumer handshake
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (itr === 1'b1) itr_cnt++;
            if (req_in === 1'b1) begin
                if (q_rd.size() == 0) check("rd_queue_underflow", 32'd1, 32'd0);
                else check("rd_data", {16'h0, io_in}, {16'h0, q_rd.pop_front()});
            end
            if (out_valid[0] && out_ready[0]) begin
                if (q_out0.size() == 0) check("out0_queue_underflow", 32'd1, 32'd0);
                else check("out0_data", {16'h0, out_data[15:0]}, {16'h0, q_out0.pop_front()});
            end
            if (out_valid[1] && out_ready[1]) begin
                if (q_out1.size() == 0) check("out1_queue_underflow", 32'd1, 32'd0);
                else check("out1_data", {16'h0, out_data[31:16]}, {16'h0, q_out1.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1; addr_in = '0; req_in = 1'b0; io_out = '0; addr_out = '0;
        out_en = 1'b0; in_data = '0; in_valid = '0; out_ready = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset / idle state
        @(negedge clk);
        check("rst_in_ready", {30'h0, in_ready}, 32'h3);
        check("rst_out_valid", {30'h0, out_valid}, 32'h0);
        check("rst_err", {30'h0, err}, 32'h0);
        check("rst_itr", {31'h0, itr}, 32'h0);
        check("rst_io_in", {16'h0, io_in}, 32'h0);
        check("rst_out_data", out_data, 32'h0);

        // Producer 0x1234 on channel 1, read two cycles later
        tick(); in_data = {16'h1234, 16'h0000}; in_valid = 2'b10;
        tick(); in_valid = 2'b00;
        @(negedge clk);
        check("ch1_full_in_ready", {30'h0, in_ready}, 32'h1);
        check("itr_not_yet", {31'h0, itr}, 32'h0);
        tick();
        @(negedge clk);
        check("itr_pulse", {31'h0, itr}, ITR_ON);
        exp_itr += ITR_ON;
        tick(); req_in = 1'b1; addr_in = 1'b1; q_rd.push_back(16'h1234);
        @(negedge clk);
        check("itr_single_cycle", {31'h0, itr}, 32'h0);
        tick(); req_in = 1'b0;
        @(negedge clk);
        check("ch1_freed", {30'h0, in_ready}, 32'h3);
        check("no_err_after_read", {30'h0, err}, 32'h0);
        tick(); tick();
        check("itr_count_1", itr_cnt, exp_itr);

        // Read of empty channel 0
        tick(); req_in = 1'b1; addr_in = 1'b0; q_rd.push_back(16'h0000);
        tick(); req_in = 1'b0;
        @(negedge clk);
        check("underrun_set", {30'h0, err}, 32'h1);
        tick(); tick(); tick();
        check("underrun_sticky", {30'h0, err}, 32'h1);

        // Read and producer write on the same empty slot: stale data, write kept
        tick(); req_in = 1'b1; addr_in = 1'b0; q_rd.push_back(16'h0000);
        in_data = {16'h0000, 16'h7777}; in_valid = 2'b01;
        tick(); req_in = 1'b0; in_valid = 2'b00;
        @(negedge clk);
        check("rdwr_write_kept", {30'h0, in_ready}, 32'h2);
        tick(); req_in = 1'b1; addr_in = 1'b0; q_rd.push_back(16'h7777);
        exp_itr += ITR_ON;
        tick(); req_in = 1'b0;
        @(negedge clk);
        check("rdwr_freed", {30'h0, in_ready}, 32'h3);
        check("rdwr_err", {30'h0, err}, 32'h1);

        // Write channel 1 while consumer drains previous value: no overrun
        tick(); out_en = 1'b1; addr_out = 1'b1; io_out = 16'h0005;
        tick(); io_out = 16'h0001; out_ready = 2'b10; q_out1.push_back(16'h0005);
        tick(); out_en = 1'b0; out_ready = 2'b00;
        @(negedge clk);
        check("wd_valid_kept", {30'h0, out_valid}, 32'h2);
        check("wd_data", {16'h0, out_data[31:16]}, 32'h0001);
        check("wd_err_unchanged", {30'h0, err}, 32'h1);
        tick(); out_ready = 2'b10; q_out1.push_back(16'h0001);
        tick(); out_ready = 2'b00;
        @(negedge clk);
        check("wd_drained", {30'h0, out_valid}, 32'h0);

        // Overwrite of undrained channel 0
        tick(); out_en = 1'b1; addr_out = 1'b0; io_out = 16'hBEEF;
        tick(); io_out = 16'hCAFE;
        tick(); out_en = 1'b0;
        @(negedge clk);
        check("ovr_data", {16'h0, out_data[15:0]}, 32'hCAFE);
        check("ovr_valid", {30'h0, out_valid}, 32'h1);
        check("ovr_err", {30'h0, err}, 32'h3);
        tick(); out_ready = 2'b01; q_out0.push_back(16'hCAFE);
        tick(); out_ready = 2'b00;
        @(negedge clk);
        check("ovr_drained", {30'h0, out_valid}, 32'h0);

        // Fill both inputs, then reset before the interrupt can fire
        tick(); in_data = {16'h5555, 16'hAAAA}; in_valid = 2'b11;
        tick(); in_valid = 2'b00; rst = 1'b1;
        @(negedge clk);
        check("fill_both", {30'h0, in_ready}, 32'h0);
        tick(); rst = 1'b0;
        @(negedge clk);
        check("rst_mid_empty", {30'h0, in_ready}, 32'h3);
        check("rst_mid_err", {30'h0, err}, 32'h0);
        check("rst_mid_itr", {31'h0, itr}, 32'h0);
        tick(); tick(); tick();
        check("rst_mid_no_itr", itr_cnt, exp_itr);
        tick(); req_in = 1'b1; addr_in = 1'b1; q_rd.push_back(16'h0000);
        tick(); req_in = 1'b0;
        @(negedge clk);
        check("rst_hold_cleared_err", {30'h0, err}, 32'h1);

        tick(); tick();
        check("rd_queue_drained", q_rd.size(), 32'd0);
        check("out_queues_drained", q_out0.size() + q_out1.size(), 32'd0);
        check("itr_total", itr_cnt, exp_itr);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
